// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port among three requesters with round-robin,
// burst-bounded ownership and returns each read word to its issuer through a tag pipeline.
module sram_port_arbiter #(
   parameter int READ_LATENCY = 2,
   parameter int MAX_BURST    = 16
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [2:0]  i_req,
   input  logic [2:0]  i_we_n,
   input  logic [53:0] i_address,
   input  logic [47:0] i_write_data,
   output logic [2:0]  o_grant,
   output logic [2:0]  o_read_valid,
   output logic [15:0] o_read_data,
   output logic [17:0] o_sram_address,
   output logic [15:0] o_sram_write_data,
   output logic        o_sram_we_n,
   input  logic [15:0] i_sram_read_data
);
   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int PD = READ_LATENCY + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

   logic [2:0]         r_grant;
   logic [CW-1:0]      r_count;
   logic [1:0]         r_last;
   logic [PD-1:0]      r_tag_v;
   logic [PD-1:0][1:0] r_tag_p;
   logic [2:0]         r_read_valid;
   logic [15:0]        r_read_data;
   logic [17:0]        r_sram_addr;
   logic [15:0]        r_sram_wd;
   logic               r_sram_we_n;
   logic               w_accept;
   logic               w_others;
   logic               w_keep;
   logic [1:0]         w_port;
   logic [1:0]         w_p1;
   logic [1:0]         w_p2;
   logic [2:0]         w_pick_rot;
   logic [2:0]         w_pick_arb;
   logic [2:0]         w_grant_nxt;
   logic [CW-1:0]      w_count_nxt;
   logic [17:0]        w_addr;
   logic [15:0]        w_wdata;

   // The owner is always the last granted port, so rotation searches last+1, last+2.
   always_comb begin
      w_port      = r_grant[2] ? 2'd2 : r_grant[1] ? 2'd1 : 2'd0;
      w_accept    = |(r_grant & i_req);
      w_others    = |(i_req & ~r_grant);
      w_p1        = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
      w_p2        = (w_p1 == 2'd2) ? 2'd0 : w_p1 + 2'd1;
      w_pick_rot  = i_req[w_p1] ? 3'b001 << w_p1 : i_req[w_p2] ? 3'b001 << w_p2 : 3'b000;
      w_pick_arb  = (w_pick_rot != 3'b000) ? w_pick_rot : i_req[r_last] ? 3'b001 << r_last : 3'b000;
      w_keep      = w_accept && (r_count != LAST_CNT || !w_others);
      w_grant_nxt = w_keep ? r_grant : w_accept ? w_pick_rot : w_pick_arb;
      w_count_nxt = (w_keep && r_count != LAST_CNT) ? r_count + 1'b1 : '0;
      w_addr      = (w_port == 2'd2) ? i_address[53:36] : (w_port == 2'd1) ? i_address[35:18] : i_address[17:0];
      w_wdata     = (w_port == 2'd2) ? i_write_data[47:32] : (w_port == 2'd1) ? i_write_data[31:16] : i_write_data[15:0];
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_grant      <= '0;
         r_count      <= '0;
         r_last       <= 2'd2;
         r_tag_v      <= '0;
         r_tag_p      <= '0;
         r_read_valid <= '0;
         r_read_data  <= '0;
         r_sram_addr  <= '0;
         r_sram_wd    <= '0;
         r_sram_we_n  <= 1'b1;
      end else begin
         r_grant      <= w_grant_nxt;
         r_count      <= w_count_nxt;
         r_last       <= w_grant_nxt[0] ? 2'd0 : w_grant_nxt[1] ? 2'd1 : w_grant_nxt[2] ? 2'd2 : r_last;
         r_sram_we_n  <= w_accept ? i_we_n[w_port] : 1'b1;
         if (w_accept) begin
            r_sram_addr <= w_addr;
            r_sram_wd   <= w_wdata;
         end
         r_tag_v      <= {r_tag_v[PD-2:0], w_accept & i_we_n[w_port]};
         r_tag_p      <= {r_tag_p[PD-2:0], w_port};
         r_read_valid <= r_tag_v[PD-1] ? 3'b001 << r_tag_p[PD-1] : 3'b000;
         if (r_tag_v[PD-1]) r_read_data <= i_sram_read_data;
      end
   end

   assign o_grant           = r_grant;
   assign o_read_valid      = r_read_valid;
   assign o_read_data       = r_read_data;
   assign o_sram_address    = r_sram_addr;
   assign o_sram_write_data = r_sram_wd;
   assign o_sram_we_n       = r_sram_we_n;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: scenario tasks plus a read-return scoreboard against a
// fixed-latency SRAM model whose word is a function of the address.
module tb_sram_port_arbiter;
   localparam int RL = 2;
   localparam int MB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req = 3'b000;
   logic [2:0]  we_n = 3'b111;
   logic [17:0] a [3];
   logic [15:0] wd [3];
   logic [2:0]  o_grant, o_read_valid;
   logic [15:0] o_read_data, o_sram_write_data, sram_rd;
   logic [17:0] o_sram_address, hist0, hist1;
   logic        o_sram_we_n;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [18:0] q [$];
   int          acc_cnt [3];
   bit          chk_cmd = 0;
   logic [17:0] e_addr;
   logic [15:0] e_wd;
   logic        e_we;
   logic [2:0]  m_w;
   logic [1:0]  m_p;
   logic [18:0] m_e;

   always #5 clk = ~clk;

   sram_port_arbiter #(.READ_LATENCY(RL), .MAX_BURST(MB)) dut (
      .i_clock(clk), .i_reset(rst), .i_req(req), .i_we_n(we_n),
      .i_address({a[2], a[1], a[0]}), .i_write_data({wd[2], wd[1], wd[0]}),
      .o_grant(o_grant), .o_read_valid(o_read_valid), .o_read_data(o_read_data),
      .o_sram_address(o_sram_address), .o_sram_write_data(o_sram_write_data),
      .o_sram_we_n(o_sram_we_n), .i_sram_read_data(sram_rd));

   function automatic logic [15:0] mem_word(input logic [17:0] ad);
      return ad[15:0] ^ {ad[17:16], 14'h0} ^ 16'hC35A;
   endfunction

   // SRAM model: word for the address driven RL cycles earlier
   always @(posedge clk) begin
      hist0 <= o_sram_address;
      hist1 <= hist0;
   end
   assign sram_rd = mem_word(hist1);

   // Monitor: checks the command issued after each accept and pops read returns
   always @(negedge clk) begin
      n_checks++;
      if (chk_cmd ? (o_sram_address !== e_addr || o_sram_write_data !== e_wd || o_sram_we_n !== e_we)
                  : (o_sram_we_n !== 1'b1)) begin
         n_fail++;
         $display("FAIL sram_cmd @%0t: got addr=%h data=%h we_n=%b want addr=%h data=%h we_n=%b",
                  $time, o_sram_address, o_sram_write_data, o_sram_we_n,
                  chk_cmd ? e_addr : o_sram_address, chk_cmd ? e_wd : o_sram_write_data, chk_cmd ? e_we : 1'b1);
      end
      if (o_read_valid !== 3'b000) begin
         n_checks++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL read_return @%0t: got valid=%b data=%h want no return", $time, o_read_valid, o_read_data);
         end else begin
            m_e = q.pop_front();
            if ({o_read_valid, o_read_data} !== m_e) begin
               n_fail++;
               $display("FAIL read_return @%0t: got valid=%b data=%h want valid=%b data=%h",
                        $time, o_read_valid, o_read_data, m_e[18:16], m_e[15:0]);
            end
         end
      end
      m_w = o_grant & req;
      chk_cmd = 0;
      if (!rst && m_w != 3'b000) begin
         m_p = m_w[1] ? 2'd1 : m_w[2] ? 2'd2 : 2'd0;
         chk_cmd = 1;
         e_addr = a[m_p];
         e_wd = wd[m_p];
         e_we = we_n[m_p];
         acc_cnt[m_p]++;
         if (we_n[m_p]) q.push_back({m_w, mem_word(a[m_p])});
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
      end
   endtask

   task automatic do_reset;
      tick;
      rst = 1'b1;
      req = 3'b000;
      tick;
      q.delete();
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      tick;
      tick;
      @(negedge clk);
      if (o_grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", o_grant); end
      n_checks++;
      if (o_read_valid !== 3'b000) begin n_fail++; $display("FAIL reset_rv: got %b want 000", o_read_valid); end
      n_checks++;
      if (o_read_data !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", o_read_data); end
      n_checks++;
      if (o_sram_address !== 18'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 00000", o_sram_address); end
      n_checks++;
      if (o_sram_write_data !== 16'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0000", o_sram_write_data); end
      n_checks++;
      if (o_sram_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b want 1", o_sram_we_n); end
      n_checks++;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_single_read;
      tick;
      a[1] = 18'h12C00;
      we_n[1] = 1'b1;
      req[1] = 1'b1;
      tick;
      @(negedge clk);
      if (o_grant !== 3'b010) begin n_fail++; $display("FAIL rd_grant: got %b want 010", o_grant); end
      n_checks++;
      tick;
      req[1] = 1'b0;
      @(negedge clk);
      if (o_sram_address !== 18'h12C00 || o_sram_we_n !== 1'b1) begin
         n_fail++;
         $display("FAIL rd_cmd: got addr=%h we_n=%b want addr=12c00 we_n=1", o_sram_address, o_sram_we_n);
      end
      n_checks++;
      for (int c = 3; c <= 3 + RL; c++) begin
         tick;
         @(negedge clk);
         if (c == 3) chk("rd_grant_release", {29'd0, o_grant}, 32'd0);
         chk("rd_valid", {29'd0, o_read_valid}, (c == 3 + RL) ? 32'd2 : 32'd0);
      end
      if (o_read_data !== mem_word(18'h12C00)) begin
         n_fail++;
         $display("FAIL rd_data: got %h want %h", o_read_data, mem_word(18'h12C00));
      end
      n_checks++;
   endtask

   task automatic test_single_write;
      int lows = 0;
      int rvs = 0;
      tick;
      a[0] = 18'd76800;
      wd[0] = 16'hA5C3;
      we_n[0] = 1'b0;
      req[0] = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick;
         if (c == 2) req[0] = 1'b0;
         @(negedge clk);
         if (o_sram_we_n === 1'b0) begin
            lows++;
            if (o_sram_address !== 18'd76800 || o_sram_write_data !== 16'hA5C3) begin
               n_fail++;
               $display("FAIL wr_cmd: got addr=%h data=%h want addr=12c00 data=a5c3", o_sram_address, o_sram_write_data);
            end
            n_checks++;
         end
         if (o_read_valid !== 3'b000) rvs++;
      end
      chk("wr_we_low_cycles", lows, 1);
      chk("wr_no_read_valid", rvs, 0);
      we_n[0] = 1'b1;
   endtask

   task automatic test_contention;
      logic [2:0] exp;
      do_reset;
      a[0] = 18'h00100;
      a[1] = 18'h01234;
      a[2] = 18'h3ABCD;
      we_n = 3'b111;
      tick;
      req = 3'b111;
      for (int c = 1; c <= 13; c++) begin
         tick;
         @(negedge clk);
         exp = (c <= MB) ? 3'b001 : (c <= 2 * MB) ? 3'b010 : (c <= 3 * MB) ? 3'b100 : 3'b001;
         chk("contention_grant", {29'd0, o_grant}, {29'd0, exp});
      end
      tick;
      req = 3'b000;
      repeat (8) tick;
   endtask

   task automatic test_lone_owner;
      int base = acc_cnt[2];
      tick;
      a[2] = 18'h20000;
      req = 3'b100;
      for (int c = 1; c <= 40; c++) begin
         tick;
         a[2] = 18'h20000 + 18'(c);
         wd[2] = 16'($urandom);
         we_n[2] = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("lone_grant", {29'd0, o_grant}, 32'd4);
      end
      tick;
      req = 3'b000;
      we_n[2] = 1'b1;
      chk("lone_accepts", acc_cnt[2] - base, 40);
      repeat (8) tick;
   endtask

   task automatic test_owner_drop;
      int base = acc_cnt[1];
      tick;
      a[1] = 18'h0AAA0;
      we_n[1] = 1'b1;
      req = 3'b010;
      for (int c = 1; c <= 3; c++) begin
         tick;
         a[1] = 18'h0AAA0 + 18'(c);
         @(negedge clk);
         chk("drop_p1_grant", {29'd0, o_grant}, 32'd2);
      end
      for (int c = 4; c <= 12; c++) begin
         tick;
         if (c == 4) begin
            req = 3'b001;
            a[0] = 18'h15550;
            we_n[0] = 1'b1;
         end
         if (c >= 6 && c <= 8) a[0] = 18'h15550 + 18'(c);
         if (c == 9) req = 3'b000;
         @(negedge clk);
         if (c == 4) chk("drop_bubble_grant", {29'd0, o_grant}, 32'd2);
         if (c == 4) chk("drop_p1_accepts", acc_cnt[1] - base, 3);
         if (c >= 5 && c <= 8) chk("drop_p0_grant", {29'd0, o_grant}, 32'd1);
         chk("drop_read_valid", {29'd0, o_read_valid}, (c >= 5 && c <= 7) ? 32'd2 : (c >= 9) ? 32'd1 : 32'd0);
      end
      repeat (4) tick;
   endtask

   task automatic test_reset_mid;
      int rvs = 0;
      tick;
      a[0] = 18'h30000;
      we_n[0] = 1'b1;
      req = 3'b001;
      for (int c = 1; c <= 6; c++) begin
         tick;
         a[0] = 18'h30000 + 18'(c);
      end
      tick;
      rst = 1'b1;
      req = 3'b000;
      tick;
      q.delete();
      @(negedge clk);
      chk("mid_reset_grant", {29'd0, o_grant}, 32'd0);
      chk("mid_reset_rv", {29'd0, o_read_valid}, 32'd0);
      chk("mid_reset_addr", {14'd0, o_sram_address}, 32'd0);
      chk("mid_reset_rdata", {16'd0, o_read_data}, 32'd0);
      tick;
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (o_read_valid !== 3'b000) rvs++;
         tick;
      end
      chk("mid_reset_no_stale_returns", rvs, 0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         a[i] = '0;
         wd[i] = '0;
         acc_cnt[i] = 0;
      end
      test_reset;
      test_single_read;
      test_single_write;
      test_contention;
      test_lone_owner;
      test_owner_drop;
      test_reset_mid;
      repeat (6) tick;
      chk("scoreboard_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion want finish");
      $fatal(1);
   end
endmodule
